// File: rtl/brv32p_fetch_buffer.sv
// Instruction prefetch queue: pipelined word fetches into a DEPTH-word buffer,
// with halfword realignment so instructions split across words reach IF whole.
module brv32p_fetch_buffer #(
  parameter int unsigned DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rerr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        instr_compressed,
  output logic        instr_fault
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;  // word pointer / counter width, incl. phase bit
  localparam int unsigned HW = AW + 2;  // halfword pointer width
  localparam logic [CW:0] DEPTH_X = DEPTH[CW:0];

  logic [31:0]   word_q [DEPTH];
  logic [31:0]   word_d [DEPTH];
  logic          err_q  [DEPTH];
  logic          err_d  [DEPTH];
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [HW-1:0] hp_q, hp_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   head_pc_q, head_pc_d;

  logic [CW-1:0] occ;
  logic [CW:0]   inflight;
  logic [AW-1:0] idx0, idx1;
  logic [15:0]   hw0, hw1;
  logic          err0, err1;
  logic          is_comp, hw0_ok, hw1_ok, avail, req_int;
  logic          req_fire, push, pop;
  logic          unused_pc_bit0;

  assign unused_pc_bit0 = redirect_pc[0];

  // Occupancy counts a word until both of its halfwords have been consumed.
  always_comb begin
    occ      = wr_ptr_q - hp_q[HW-1:1];
    inflight = {1'b0, occ} + {1'b0, out_cnt_q};
    req_int  = (inflight < DEPTH_X);
    idx0     = hp_q[AW:1];
    idx1     = idx0 + AW'(1);
    hw0      = hp_q[0] ? word_q[idx0][31:16] : word_q[idx0][15:0];
    err0     = err_q[idx0];
    hw1      = hp_q[0] ? word_q[idx1][15:0] : word_q[idx0][31:16];
    err1     = hp_q[0] ? err_q[idx1] : err_q[idx0];
    is_comp  = (hw0[1:0] != 2'b11);
    hw0_ok   = (occ != '0);
    hw1_ok   = hp_q[0] ? (occ > CW'(1)) : hw0_ok;
    avail    = hw0_ok && (is_comp || hw1_ok);
  end

  assign imem_req         = rst_n & req_int;
  assign imem_addr        = rst_n ? fetch_pc_q : 32'h0;
  assign instr_valid      = rst_n & avail;
  assign instr_data       = !rst_n ? 32'h0 : (is_comp ? {16'h0, hw0} : {hw1, hw0});
  assign instr_pc         = rst_n ? head_pc_q : 32'h0;
  assign instr_compressed = rst_n & is_comp;
  assign instr_fault      = rst_n & (err0 | (~is_comp & err1));

  assign req_fire = imem_req & imem_gnt;
  assign pop      = instr_valid & instr_ready & ~redirect_valid;
  assign push     = imem_rvalid & (discard_q == '0) & ~redirect_valid;

  always_comb begin
    word_d     = word_q;
    err_d      = err_q;
    wr_ptr_d   = wr_ptr_q;
    hp_d       = hp_q;
    discard_d  = discard_q;
    fetch_pc_d = fetch_pc_q;
    head_pc_d  = head_pc_q;
    out_cnt_d  = out_cnt_q;
    if (req_fire && !imem_rvalid) begin
      out_cnt_d = out_cnt_q + CW'(1);
    end else if (!req_fire && imem_rvalid) begin
      out_cnt_d = out_cnt_q - CW'(1);
    end
    if (redirect_valid) begin
      // Every response still owed after this cycle belongs to the old stream.
      wr_ptr_d   = '0;
      hp_d       = {{CW{1'b0}}, redirect_pc[1]};
      discard_d  = out_cnt_d;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      head_pc_d  = {redirect_pc[31:1], 1'b0};
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (imem_rvalid && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1);
      end
      if (push) begin
        word_d[wr_ptr_q[AW-1:0]] = imem_rdata;
        err_d[wr_ptr_q[AW-1:0]]  = imem_rerr;
        wr_ptr_d                 = wr_ptr_q + CW'(1);
      end
      if (pop) begin
        hp_d      = hp_q + (is_comp ? HW'(1) : HW'(2));
        head_pc_d = head_pc_q + (is_comp ? 32'd2 : 32'd4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      hp_q       <= {{CW{1'b0}}, RESET_VECTOR[1]};
      out_cnt_q  <= '0;
      discard_q  <= '0;
      fetch_pc_q <= {RESET_VECTOR[31:2], 2'b00};
      head_pc_q  <= RESET_VECTOR;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      hp_q       <= hp_d;
      out_cnt_q  <= out_cnt_d;
      discard_q  <= discard_d;
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
    end
  end

  // Buffer storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    word_q <= word_d;
    err_q  <= err_d;
  end

endmodule

// File: tb/tb_brv32p_fetch_buffer.sv
// Bench for brv32p_fetch_buffer: in-order memory responder plus a PC-based
// reference of the instruction stream, checked every cycle.
`timescale 1ns/1ps
module tb_brv32p_fetch_buffer;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0000_0100;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_rerr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_compressed;
  logic        instr_fault;

  always #5 clk = ~clk;

  brv32p_fetch_buffer #(.DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_rerr(imem_rerr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .instr_compressed(instr_compressed), .instr_fault(instr_fault)
  );

  // Memory image: 256 words, indexed by address bits [9:2].
  logic [31:0] memw [256];
  logic        meme [256];

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; logic comp; logic fault; int cyc; } ilog_t;
  pend_t       pend [$];
  ilog_t       ilog [$];
  logic [31:0] glog [$];

  int n_cmp, n_bad, cyc;
  logic [31:0] m_fetch, m_pc;
  int          m_nw, m_out, m_disc;

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = memw[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic logic err_at(input logic [31:0] a);
    return meme[a[9:2]];
  endfunction

  function automatic ilog_t get_i(input int k);
    ilog_t r;
    r.pc = 32'hDEAD_BEEF; r.data = 32'hDEAD_BEEF; r.comp = 1'bx; r.fault = 1'bx; r.cyc = -1000;
    if (k >= 0 && k < ilog.size()) r = ilog[k];
    return r;
  endfunction

  function automatic logic [31:0] get_g(input int k);
    if (k >= 0 && k < glog.size()) return glog[k];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fill(input logic [31:0] base, input int n, input logic [31:0] w);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + 32'(4 * i);
      memw[a[9:2]] = w;
      meme[a[9:2]] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      imem_gnt = 1'($urandom_range(0, 1)); imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata = $urandom; imem_rerr = 1'($urandom_range(0, 1));
      instr_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
      chk("rst_imem_addr", imem_addr, 32'd0);
      chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_instr_data", instr_data, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
      chk("rst_instr_comp", {31'b0, instr_compressed}, 32'd0);
      chk("rst_instr_fault", {31'b0, instr_fault}, 32'd0);
      @(posedge clk); #1; cyc++;
    end
    pend.delete();
    m_fetch = {RV[31:2], 2'b00}; m_pc = RV; m_nw = 0; m_out = 0; m_disc = 0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, advance the model.
  task automatic step(input bit g, input bit rv_en, input bit rdy, input bit rd,
                      input logic [31:0] rpc, input int lat);
    logic [15:0] h0, h1;
    logic [31:0] e_data, npc, a;
    bit comp, e_req, e_vld, fire_m, rv, push;
    int avail;
    imem_gnt = g; instr_ready = rdy; redirect_valid = rd; redirect_pc = rpc;
    if (rv_en && pend.size() > 0 && pend[0].due <= cyc) begin
      a = pend[0].addr;
      imem_rvalid = 1'b1; imem_rdata = memw[a[9:2]]; imem_rerr = meme[a[9:2]];
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom; imem_rerr = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    e_req = (m_nw + m_out) < DEPTH;
    chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
    if (e_req) chk("imem_addr", imem_addr, m_fetch);
    h0 = hw_at(m_pc);
    h1 = hw_at(m_pc + 32'd2);
    comp = (h0[1:0] != 2'b11);
    avail = 2 * m_nw - (m_pc[1] ? 1 : 0);
    e_vld = (avail >= 1) && (comp || avail >= 2);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, e_vld});
    if (e_vld && instr_valid) begin
      e_data = comp ? {16'h0, h0} : {h1, h0};
      chk("instr_pc", instr_pc, m_pc);
      chk("instr_data", instr_data, e_data);
      chk("instr_compressed", {31'b0, instr_compressed}, {31'b0, comp});
      chk("instr_fault", {31'b0, instr_fault},
          {31'b0, comp ? err_at(m_pc) : (err_at(m_pc) | err_at(m_pc + 32'd2))});
    end
    if (imem_rvalid) void'(pend.pop_front());
    if (imem_req && imem_gnt) begin
      glog.push_back(imem_addr);
      pend.push_back('{imem_addr, cyc + lat});
    end
    if (instr_valid && instr_ready && !redirect_valid)
      ilog.push_back('{instr_pc, instr_data, instr_compressed, instr_fault, cyc});
    fire_m = e_req && g;
    rv = imem_rvalid;
    m_out = m_out + (fire_m ? 1 : 0) - (rv ? 1 : 0);
    if (rd) begin
      m_disc = m_out; m_nw = 0;
      m_fetch = {rpc[31:2], 2'b00};
      m_pc = {rpc[31:1], 1'b0};
    end else begin
      if (fire_m) m_fetch = m_fetch + 32'd4;
      push = rv && (m_disc == 0);
      if (rv && m_disc > 0) m_disc--;
      if (e_vld && rdy) begin
        npc = m_pc + (comp ? 32'd2 : 32'd4);
        m_nw = m_nw - int'((npc >> 2) - (m_pc >> 2));
        m_pc = npc;
      end
      if (push) m_nw++;
    end
    @(posedge clk); #1; cyc++;
  endtask

  initial begin
    ilog_t e;
    int gb, bi, stall;
    bit g, rve, rdy, rd, prev_rd;
    logic [31:0] rpc;
    n_cmp = 0; n_bad = 0; cyc = 0;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; imem_rerr = 1'b0; instr_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin memw[i] = $urandom; meme[i] = 1'b0; end

    // Streaming NOPs from the reset vector, one instruction per cycle.
    fill(32'h100, 16, NOP);
    do_reset();
    gb = glog.size(); bi = ilog.size();
    repeat (12) step(1, 1, 1, 0, 32'h0, 1);
    for (int i = 0; i < 4; i++) begin
      chk("a1_imem_addr", get_g(gb + i), 32'h100 + 32'(4 * i));
      e = get_i(bi + i);
      chk("a1_instr_pc", e.pc, 32'h100 + 32'(4 * i));
      chk("a1_rate", 32'(e.cyc - get_i(bi).cyc), 32'(i));
    end

    // c.nop followed by a 32-bit instruction split across the word boundary.
    memw[8'h40] = 32'h0013_0001; memw[8'h41] = 32'h0001_0000;
    do_reset();
    bi = ilog.size();
    repeat (12) step(1, 1, 1, 0, 32'h0, 1);
    e = get_i(bi);
    chk("a2_pc0", e.pc, 32'h100); chk("a2_data0", e.data, 32'h1); chk("a2_comp0", {31'b0, e.comp}, 32'd1);
    e = get_i(bi + 1);
    chk("a2_pc1", e.pc, 32'h102); chk("a2_data1", e.data, 32'h13); chk("a2_comp1", {31'b0, e.comp}, 32'd0);
    e = get_i(bi + 2);
    chk("a2_pc2", e.pc, 32'h106); chk("a2_data2", e.data, 32'h1);
    e = get_i(bi + 3);
    chk("a2_pc3", e.pc, 32'h108);

    // IF stalled: buffer fills to DEPTH words, then drains in order.
    fill(32'h100, 32, NOP);
    do_reset();
    gb = glog.size();
    repeat (20) step(1, 1, 0, 0, 32'h0, 1);
    chk("b_grants", 32'(glog.size() - gb), 32'(DEPTH));
    chk("b_req_when_full", {31'b0, imem_req}, 32'd0);
    bi = ilog.size();
    repeat (20) step(1, 1, 1, 0, 32'h0, 1);
    for (int i = 0; i < 8; i++) begin
      e = get_i(bi + i);
      chk("b_drain_pc", e.pc, 32'h100 + 32'(4 * i));
    end

    // Redirect to an upper halfword with two responses still outstanding.
    memw[8'h80] = 32'h0001_0013;
    fill(32'h204, 8, NOP);
    do_reset();
    gb = glog.size(); bi = ilog.size();
    step(1, 0, 1, 0, 32'h0, 1);
    step(1, 0, 1, 0, 32'h0, 1);
    step(0, 0, 1, 1, 32'h202, 1);
    repeat (15) step(1, 1, 1, 0, 32'h0, 1);
    chk("c_first_new_addr", get_g(gb + 2), 32'h200);
    e = get_i(bi);
    chk("c_pc0", e.pc, 32'h202); chk("c_data0", e.data, 32'h1);
    e = get_i(bi + 1);
    chk("c_pc1", e.pc, 32'h204); chk("c_data1", e.data, NOP);

    // Bus error on the word holding the upper half of a split instruction.
    memw[8'h40] = 32'h0013_0001; meme[8'h40] = 1'b0;
    memw[8'h41] = 32'h0001_0000; meme[8'h41] = 1'b1;
    do_reset();
    bi = ilog.size();
    repeat (12) step(1, 1, 1, 0, 32'h0, 1);
    e = get_i(bi);     chk("d_fault_cnop", {31'b0, e.fault}, 32'd0);
    e = get_i(bi + 1); chk("d_fault_split", {31'b0, e.fault}, 32'd1); chk("d_pc_split", e.pc, 32'h102);
    e = get_i(bi + 3); chk("d_fault_clean", {31'b0, e.fault}, 32'd0); chk("d_pc_clean", e.pc, 32'h108);
    meme[8'h41] = 1'b0;

    // Redirect coinciding with rvalid, gnt and valid&ready.
    fill(32'h100, 32, NOP);
    fill(32'h300, 8, NOP);
    do_reset();
    repeat (6) step(1, 1, 1, 0, 32'h0, 1);
    chk("e_setup_valid", {31'b0, instr_valid}, 32'd1);
    chk("e_setup_req", {31'b0, imem_req}, 32'd1);
    chk("e_setup_pending", 32'(pend.size()), 32'd1);
    gb = glog.size(); bi = ilog.size();
    step(1, 1, 1, 1, 32'h300, 1);
    repeat (12) step(1, 1, 1, 0, 32'h0, 1);
    chk("e_first_new_addr", get_g(gb + 1), 32'h300);
    e = get_i(bi);
    chk("e_first_pc", e.pc, 32'h300);

    // Randomised traffic: random image, bus errors, stalls, latency and redirects.
    for (int i = 0; i < 256; i++) begin
      memw[i] = $urandom;
      meme[i] = ($urandom_range(0, 11) == 0);
    end
    do_reset();
    prev_rd = 1'b0; stall = 0;
    for (int i = 0; i < 4000; i++) begin
      g   = ($urandom_range(0, 3) != 0);
      rve = ($urandom_range(0, 9) < 7);
      if (stall > 0) begin
        rdy = 1'b0; stall--;
      end else begin
        rdy = ($urandom_range(0, 9) < 8);
        if ($urandom_range(0, 60) == 0) stall = 15;
      end
      rd  = prev_rd ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
      rpc = 32'($urandom_range(0, 1023));
      step(g, rve, rdy, rd, rpc, $urandom_range(1, 3));
      prev_rd = rd;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
